// File: rtl/sent_pkg.sv
// Shared SENT definitions: timing constants, frame payload, state encoding,
// the J2716 CRC4 lookup table and a nibble selector.
package sent_pkg;

    localparam int unsigned SYNC_TICKS   = 56;
    localparam int unsigned NIBBLE_BASE  = 12;
    localparam int unsigned PAUSE_MIN    = 12;
    localparam int unsigned PAUSE_MAX    = 768;
    localparam logic [3:0]  CRC_SEED     = 4'h5;
    localparam int unsigned DATA_NIBBLES = 6;
    localparam int unsigned PULSE_W      = 10;
    localparam int unsigned SUM_W        = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_STATUS = 3'd2,
        ST_DATA   = 3'd3,
        ST_CRC    = 3'd4,
        ST_PAUSE  = 3'd5
    } sent_tx_state_t;

    // One fast-channel frame word as captured on accept.
    typedef struct packed {
        logic [3:0]  status;
        logic [23:0] data;
    } sent_frame_t;

    // J2716 recommended CRC4 table.
    function automatic logic [3:0] crc4_table(input logic [3:0] idx);
        logic [3:0] t;
        case (idx)
            4'd0:    t = 4'd0;
            4'd1:    t = 4'd13;
            4'd2:    t = 4'd7;
            4'd3:    t = 4'd10;
            4'd4:    t = 4'd14;
            4'd5:    t = 4'd3;
            4'd6:    t = 4'd9;
            4'd7:    t = 4'd4;
            4'd8:    t = 4'd1;
            4'd9:    t = 4'd12;
            4'd10:   t = 4'd6;
            4'd11:   t = 4'd11;
            4'd12:   t = 4'd15;
            4'd13:   t = 4'd2;
            4'd14:   t = 4'd8;
            default: t = 4'd5;
        endcase
        return t;
    endfunction

    // Data nibble by transmit order; index 0 is the most significant nibble.
    function automatic logic [3:0] data_nibble(input logic [23:0] data, input logic [2:0] idx);
        logic [3:0] n;
        case (idx)
            3'd0:    n = data[23:20];
            3'd1:    n = data[19:16];
            3'd2:    n = data[15:12];
            3'd3:    n = data[11:8];
            3'd4:    n = data[7:4];
            3'd5:    n = data[3:0];
            default: n = 4'h0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sent_crc4_calc.sv
// Nibble-serial SENT CRC4 engine (seeded, zero-nibble augmented).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         load the seed and begin a new CRC
//   nibble_valid  nibble is consumed this clock (while active)
//   nibble        next data nibble
//   crc           running / final CRC value
//   done          one-cycle pulse when crc holds the final value
module sent_crc4_calc
    import sent_pkg::*;
#(
    parameter int unsigned NIBBLES = DATA_NIBBLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       nibble_valid,
    input  logic [3:0] nibble,
    output logic [3:0] crc,
    output logic       done
);

    localparam int unsigned CNT_W = $clog2(NIBBLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES);

    logic [3:0]       crc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic             done_q;

    // After the last nibble one extra table step performs the augmentation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q    <= 4'h0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                crc_q    <= CRC_SEED;
                cnt_q    <= '0;
                active_q <= 1'b1;
            end else if (active_q) begin
                if (cnt_q == CNT_LAST) begin
                    crc_q    <= crc4_table(crc_q);
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end else if (nibble_valid) begin
                    crc_q <= crc4_table(crc_q) ^ nibble;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign crc  = crc_q;
    assign done = done_q;

endmodule

// File: rtl/sent_tx_frame_gen.sv
// SENT fast-channel transmitter: accepts a status + 6-nibble word, computes
// its CRC4 and serialises sync/status/data/CRC/(pause) pulses onto sent_tx_o.
// Ports:
//   clk_tx, reset_tx  clock, asynchronous active-high reset
//   frame_valid_i     frame word available
//   frame_ready_o     word accepted this cycle if valid (idle or last frame clock)
//   status_i, data_i  frame word, data_i[23:20] sent first
//   sent_tx_o         SENT line, idle high
//   busy_o            frame in progress
//   frame_done_o      pulse in the last clock of a frame
//   crc_o             CRC of the current/last frame
module sent_tx_frame_gen
    import sent_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 3,
    parameter int unsigned LOW_TICKS   = 5,
    parameter int unsigned PAUSE_EN    = 0,
    parameter int unsigned FRAME_TICKS = 282
) (
    input  logic        clk_tx,
    input  logic        reset_tx,
    input  logic        frame_valid_i,
    output logic        frame_ready_o,
    input  logic [3:0]  status_i,
    input  logic [23:0] data_i,
    output logic        sent_tx_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic [3:0]  crc_o
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [PULSE_W-1:0] LOW_LEN  = PULSE_W'(LOW_TICKS);
    localparam logic [2:0]         NIB_LAST = 3'(DATA_NIBBLES - 1);

    sent_tx_state_t     state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [PULSE_W-1:0] ptick_q, ptick_d;
    logic [2:0]         nib_q, nib_d;

    sent_frame_t        frame_q;
    logic [2:0]         feed_q;
    logic               feed_valid;
    logic [3:0]         crc_val;
    logic               crc_done;

    logic [SUM_W-1:0]   frame_sum;
    logic [SUM_W-1:0]   pause_raw;
    logic [PULSE_W-1:0] pause_len;
    logic [PULSE_W-1:0] cur_len, nxt_len;

    logic accept;
    logic tick_end, pulse_end;
    logic frame_last_d;
    logic tx_d, busy_d, done_d, ready_d;

    // Length in ticks of the pulse a given state/index transmits.
    function automatic logic [PULSE_W-1:0] pulse_len(
        input sent_tx_state_t     st,
        input logic [2:0]         idx,
        input sent_frame_t        fr,
        input logic [3:0]         crc,
        input logic [PULSE_W-1:0] pause
    );
        logic [PULSE_W-1:0] len;
        case (st)
            ST_STATUS: len = PULSE_W'(NIBBLE_BASE) + PULSE_W'(fr.status);
            ST_DATA:   len = PULSE_W'(NIBBLE_BASE) + PULSE_W'(data_nibble(fr.data, idx));
            ST_CRC:    len = PULSE_W'(NIBBLE_BASE) + PULSE_W'(crc);
            ST_PAUSE:  len = pause;
            default:   len = PULSE_W'(SYNC_TICKS);
        endcase
        return len;
    endfunction

    // The pulse whose last clock ends the frame.
    function automatic logic is_final(input sent_tx_state_t st);
        return (PAUSE_EN != 0) ? (st == ST_PAUSE) : (st == ST_CRC);
    endfunction

    assign accept = frame_valid_i && frame_ready_o;

    // Word capture, CRC nibble feed and CRC result holding.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            frame_q <= '0;
            feed_q  <= 3'(DATA_NIBBLES);
            crc_o   <= 4'h0;
        end else begin
            if (accept) begin
                frame_q.status <= status_i;
                frame_q.data   <= data_i;
                feed_q         <= 3'd0;
            end else if (feed_valid) begin
                feed_q <= feed_q + 3'd1;
            end
            if (crc_done) begin
                crc_o <= crc_val;
            end
        end
    end

    assign feed_valid = (feed_q < 3'(DATA_NIBBLES));

    // CRC runs during SYNC, far ahead of the CRC pulse.
    sent_crc4_calc #(
        .NIBBLES (DATA_NIBBLES)
    ) u_crc (
        .clk          (clk_tx),
        .rst          (reset_tx),
        .start        (accept),
        .nibble_valid (feed_valid),
        .nibble       (data_nibble(frame_q.data, feed_q)),
        .crc          (crc_val),
        .done         (crc_done)
    );

    // Pause pads the frame to FRAME_TICKS, bounded to [PAUSE_MIN, PAUSE_MAX].
    always_comb begin
        frame_sum = SUM_W'(SYNC_TICKS + 8 * NIBBLE_BASE) + SUM_W'(frame_q.status) + SUM_W'(crc_o);
        for (int i = 0; i < int'(DATA_NIBBLES); i++) begin
            frame_sum = frame_sum + SUM_W'(data_nibble(frame_q.data, 3'(i)));
        end
        pause_raw = SUM_W'(FRAME_TICKS) - frame_sum;
        if ((frame_sum > SUM_W'(FRAME_TICKS)) || (pause_raw < SUM_W'(PAUSE_MIN))) begin
            pause_len = PULSE_W'(PAUSE_MIN);
        end else if (pause_raw > SUM_W'(PAUSE_MAX)) begin
            pause_len = PULSE_W'(PAUSE_MAX);
        end else begin
            pause_len = pause_raw[PULSE_W-1:0];
        end
    end

    assign cur_len   = pulse_len(state_q, nib_q, frame_q, crc_o, pause_len);
    assign nxt_len   = pulse_len(state_d, nib_d, frame_q, crc_o, pause_len);
    assign tick_end  = (div_q == DIV_LAST);
    assign pulse_end = tick_end && (ptick_q == cur_len - PULSE_W'(1));

    // State register; outputs are registered from the next-cycle view.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            ptick_q       <= '0;
            nib_q         <= 3'd0;
            sent_tx_o     <= 1'b1;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_ready_o <= 1'b1;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            ptick_q       <= ptick_d;
            nib_q         <= nib_d;
            sent_tx_o     <= tx_d;
            busy_o        <= busy_d;
            frame_done_o  <= done_d;
            frame_ready_o <= ready_d;
        end
    end

    // Next state and tick/pulse counters.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ptick_d = ptick_q;
        nib_d   = nib_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                state_d = ST_SYNC;
                div_d   = '0;
                ptick_d = '0;
                nib_d   = 3'd0;
            end
        end else if (!tick_end) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = '0;
            if (!pulse_end) begin
                ptick_d = ptick_q + PULSE_W'(1);
            end else begin
                ptick_d = '0;
                case (state_q)
                    ST_SYNC: state_d = ST_STATUS;
                    ST_STATUS: begin
                        state_d = ST_DATA;
                        nib_d   = 3'd0;
                    end
                    ST_DATA: begin
                        if (nib_q == NIB_LAST) begin
                            state_d = ST_CRC;
                        end else begin
                            nib_d = nib_q + 3'd1;
                        end
                    end
                    ST_CRC: begin
                        if (PAUSE_EN != 0) begin
                            state_d = ST_PAUSE;
                        end else begin
                            state_d = accept ? ST_SYNC : ST_IDLE;
                        end
                    end
                    ST_PAUSE: state_d = accept ? ST_SYNC : ST_IDLE;
                    default:  state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Output values for the next clock; ready doubles as the frame-end marker.
    always_comb begin
        frame_last_d = is_final(state_d) && (div_d == DIV_LAST) &&
                       (ptick_d == nxt_len - PULSE_W'(1));
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = frame_last_d;
        ready_d = 1'b1;
        if (state_d != ST_IDLE) begin
            tx_d    = (ptick_d >= LOW_LEN);
            busy_d  = 1'b1;
            ready_d = frame_last_d;
        end
    end

endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Scoreboard bench for sent_tx_frame_gen: instance A (no pause) and
// instance B (pause enabled); a monitor measures pulses on the selected one.
module tb_sent_tx_frame_gen;

    localparam int TICK_DIV     = 3;
    localparam int LOW_TICKS    = 5;
    localparam int CYCLE_BUDGET = 5000;

    logic        clk_tx = 1'b0;
    logic        reset_tx;
    logic        frame_valid;
    logic [3:0]  status_i;
    logic [23:0] data_i;
    bit          sel;

    logic        val_a, val_b;
    logic        rdy_a, tx_a, busy_a, done_a;
    logic        rdy_b, tx_b, busy_b, done_b;
    logic [3:0]  crc_a, crc_b;
    logic        rdy_m, tx_m, busy_m, done_m;
    logic [3:0]  crc_m;

    int total;
    int bad;
    int exp_crc_q[$];
    int exp_n_q[$];
    int exp_gap_q[$];
    int exp_len_q[$];
    int meas[$];

    always #5 clk_tx = ~clk_tx;

    assign val_a  = frame_valid & ~sel;
    assign val_b  = frame_valid & sel;
    assign rdy_m  = sel ? rdy_b  : rdy_a;
    assign tx_m   = sel ? tx_b   : tx_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign done_m = sel ? done_b : done_a;
    assign crc_m  = sel ? crc_b  : crc_a;

    sent_tx_frame_gen #(
        .TICK_DIV (TICK_DIV), .LOW_TICKS (LOW_TICKS), .PAUSE_EN (0), .FRAME_TICKS (282)
    ) dut_a (
        .clk_tx (clk_tx), .reset_tx (reset_tx), .frame_valid_i (val_a),
        .frame_ready_o (rdy_a), .status_i (status_i), .data_i (data_i),
        .sent_tx_o (tx_a), .busy_o (busy_a), .frame_done_o (done_a), .crc_o (crc_a)
    );

    sent_tx_frame_gen #(
        .TICK_DIV (TICK_DIV), .LOW_TICKS (LOW_TICKS), .PAUSE_EN (1), .FRAME_TICKS (282)
    ) dut_b (
        .clk_tx (clk_tx), .reset_tx (reset_tx), .frame_valid_i (val_b),
        .frame_ready_o (rdy_b), .status_i (status_i), .data_i (data_i),
        .sent_tx_o (tx_b), .busy_o (busy_b), .frame_done_o (done_b), .crc_o (crc_b)
    );

    function automatic void check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Drive one word and wait for its handshake; optionally queue its expected frame.
    task automatic issue(input logic [3:0] st, input logic [23:0] d, input int crc_exp,
                         input int pause_exp, input int gap_exp, input bit scored);
        int n;
        @(negedge clk_tx);
        status_i    = st;
        data_i      = d;
        frame_valid = 1'b1;
        if (scored) begin
            exp_crc_q.push_back(crc_exp);
            exp_n_q.push_back((pause_exp != 0) ? 10 : 9);
            exp_gap_q.push_back(gap_exp);
            exp_len_q.push_back(56);
            exp_len_q.push_back(12 + int'(st));
            for (int k = 5; k >= 0; k--) begin
                exp_len_q.push_back(12 + int'((d >> (4 * k)) & 24'hF));
            end
            exp_len_q.push_back(12 + crc_exp);
            if (pause_exp != 0) exp_len_q.push_back(pause_exp);
        end
        n = 0;
        while (!rdy_m && n < CYCLE_BUDGET) begin
            @(negedge clk_tx);
            n++;
        end
        check("accept_wait", int'(n < CYCLE_BUDGET), 1);
        @(negedge clk_tx);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_crc_q.size() != 0 || busy_m) && n < CYCLE_BUDGET) begin
            @(negedge clk_tx);
            n++;
        end
        check("frame_completion", int'(n < CYCLE_BUDGET), 1);
        repeat (2) @(negedge clk_tx);
    endtask

    // Monitor: measures pulses fall-to-fall and scores each frame at frame_done.
    initial begin : monitor
        bit prev_line;
        bit in_frame;
        int pulse_clk, frame_clk, low_clk, since_done, start_gap;
        int e_crc, e_n, e_gap, e_len, tot;
        prev_line  = 1'b1;
        in_frame   = 1'b0;
        pulse_clk  = 0;
        frame_clk  = 0;
        low_clk    = 0;
        since_done = 0;
        start_gap  = 0;
        forever begin
            @(negedge clk_tx);
            since_done++;
            if (reset_tx) begin
                prev_line = 1'b1;
                in_frame  = 1'b0;
                low_clk   = 0;
                pulse_clk = 0;
                meas.delete();
            end else begin
                if (prev_line && !tx_m) begin
                    if (in_frame) begin
                        meas.push_back(pulse_clk);
                    end else begin
                        in_frame  = 1'b1;
                        frame_clk = 0;
                        start_gap = since_done;
                        meas.delete();
                    end
                    pulse_clk = 0;
                end
                if (in_frame) begin
                    pulse_clk++;
                    frame_clk++;
                end
                if (!tx_m) begin
                    low_clk++;
                end else if (low_clk != 0) begin
                    check("low_phase_clocks", low_clk, LOW_TICKS * TICK_DIV);
                    low_clk = 0;
                end
                if (done_m) begin
                    meas.push_back(pulse_clk);
                    if (exp_crc_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: actual=frame_done required=none");
                    end else begin
                        e_crc = exp_crc_q.pop_front();
                        e_n   = exp_n_q.pop_front();
                        e_gap = exp_gap_q.pop_front();
                        check("crc_o", int'(crc_m), e_crc);
                        check("pulse_count", meas.size(), e_n);
                        tot = 0;
                        for (int i = 0; i < e_n; i++) begin
                            e_len = exp_len_q.pop_front();
                            tot += e_len;
                            if (i < meas.size()) begin
                                check($sformatf("pulse%0d_clocks", i), meas[i], e_len * TICK_DIV);
                            end
                        end
                        check("frame_clocks", frame_clk, tot * TICK_DIV);
                        check("busy_at_done", int'(busy_m), 1);
                        check("ready_at_done", int'(rdy_m), 1);
                        if (e_gap != 0) check("b2b_start_gap", start_gap, e_gap);
                    end
                    in_frame   = 1'b0;
                    since_done = 0;
                end
                prev_line = tx_m;
            end
        end
    end

    initial begin : stimulus
        total       = 0;
        bad         = 0;
        sel         = 1'b0;
        frame_valid = 1'b0;
        status_i    = 4'h0;
        data_i      = 24'h0;
        reset_tx    = 1'b1;
        repeat (3) @(negedge clk_tx);
        check("reset_line", int'(tx_m), 1);
        check("reset_ready", int'(rdy_m), 1);
        check("reset_busy", int'(busy_m), 0);
        check("reset_done", int'(done_m), 0);
        check("reset_crc", int'(crc_m), 0);
        reset_tx = 1'b0;

        for (int i = 0; i < 4; i++) begin
            repeat (10) @(negedge clk_tx);
            check("idle_line", int'(tx_m), 1);
            check("idle_ready", int'(rdy_m), 1);
            check("idle_busy", int'(busy_m), 0);
        end

        // All-zero frame, then a mixed-nibble frame.
        issue(4'h0, 24'h000000, 5, 0, 0, 1'b1);
        frame_valid = 1'b0;
        drain();
        issue(4'h3, 24'h123456, 2, 0, 0, 1'b1);
        frame_valid = 1'b0;
        drain();

        // Back-to-back words with valid held; inputs change mid-frame.
        issue(4'hF, 24'hFFFFFF, 4'hA, 0, 0, 1'b1);
        issue(4'h5, 24'hABCDEF, 7, 0, 1, 1'b1);
        frame_valid = 1'b0;
        status_i    = 4'h9;
        data_i      = 24'h999999;
        drain();

        // Reset during the low phase of data nibble 3, then a clean frame.
        issue(4'h0, 24'h000000, 0, 0, 0, 1'b0);
        frame_valid = 1'b0;
        repeat (313) @(negedge clk_tx);
        check("pre_reset_line", int'(tx_m), 0);
        check("pre_reset_busy", int'(busy_m), 1);
        #1 reset_tx = 1'b1;
        #1;
        check("abort_line", int'(tx_m), 1);
        check("abort_busy", int'(busy_m), 0);
        check("abort_ready", int'(rdy_m), 1);
        check("abort_crc", int'(crc_m), 0);
        repeat (2) @(negedge clk_tx);
        reset_tx = 1'b0;
        issue(4'h3, 24'h123456, 2, 0, 0, 1'b1);
        frame_valid = 1'b0;
        drain();

        // Pause-enabled instance pads the frame to 282 ticks.
        sel = 1'b1;
        @(negedge clk_tx);
        issue(4'h0, 24'h000000, 5, 125, 0, 1'b1);
        frame_valid = 1'b0;
        drain();

        check("scoreboard_empty", exp_crc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sent_tx_frame_gen.md
Name: sent_tx_frame_gen

Overview:
- SENT (SAE J2716) fast-channel transmitter. It is the transmit-side counterpart of the SENT receive path.
- Accepts one frame word (status nibble plus six data nibbles) through a valid/ready handshake and computes the 4-bit CRC.
- Serialises sync, status, data, CRC and an optional pause pulse onto a single open-line output, timed in SENT ticks derived from the system clock.

Parameters:
- TICK_DIV, 3, clocks per SENT tick (≥2).
- LOW_TICKS, 5, low-phase length of every pulse in ticks (4..11).
- PAUSE_EN, 0, 1 = append a pause pulse padding each frame to FRAME_TICKS.
- FRAME_TICKS, 282, total frame length in ticks when PAUSE_EN=1 (≤ 1024).

Ports:
- clk_tx  in  1  system clock.
- reset_tx  in  1  asynchronous, active-high reset.
- frame_valid_i  in  1  frame word available.
- frame_ready_o  out  1  block accepts a word this cycle.
- status_i  in  4  status/communication nibble.
- data_i  in  24  six data nibbles; [23:20] sent first.
- sent_tx_o  out  1  SENT line; idle high.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse at the last clock of a frame.
- crc_o  out  4  CRC of the current/last frame; held until the next accept.

Behaviour:
- Reset values: sent_tx_o=1, frame_ready_o=1, busy_o=0, frame_done_o=0, crc_o=0; state IDLE.
- Reset asserted mid-frame aborts immediately. The line returns high and nothing is resumed.
- Handshake:
  - Accept when frame_valid_i && frame_ready_o.
  - frame_ready_o is high in IDLE and in the final clock of a frame (last clock of CRC pulse, or of pause if PAUSE_EN). This allows seamless back-to-back frames.
  - status_i and data_i are registered on accept; later input changes have no effect.
- Tick generator:
  - Counter 0..TICK_DIV-1, cleared on accept.
  - A tick ends every TICK_DIV clocks.
- Latency: sent_tx_o goes low on the clock after accept. That clock is tick 0 of the sync pulse.
- Pulse rule: every pulse is low for LOW_TICKS ticks, then high for the remainder of its length. Pulse edges fall on tick boundaries.
- States and pulse lengths:
  - IDLE.
  - SYNC: 56 ticks.
  - STATUS: 12+status ticks.
  - DATA: 6 pulses, each 12+nibble ticks; nibble index 0..5.
  - CRC: 12+crc ticks.
  - PAUSE: only if PAUSE_EN.
  - End of frame goes to SYNC if accepted in the final clock, else IDLE.
- frame_done_o pulses in the final clock of the last pulse. busy_o is high from the clock after accept to the last frame clock inclusive. busy_o stays high across back-to-back frames.
- CRC (recommended J2716 method, data nibbles only, status excluded):
  - seed 4'h5.
  - Per nibble: c = T[c] ^ nibble.
  - Final step: c = T[c] (zero-nibble augmentation).
  - T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
  - CRC is computed during SYNC, one nibble per clock, so it is ready well before the CRC state. crc_o updates when complete.
- Pause length:
  - P = FRAME_TICKS − (56 + Σ(12+nibble) over 8 pulses), computed in 11-bit unsigned.
  - If the result would be negative or < 12, use P = 12. Clamp to 768 max.
- Widths: pulse tick counter 10 bits; wrap never occurs (max pulse 768).

Decomposition:
- Shared package sent_pkg holds:
  - constants SYNC_TICKS=56, NIBBLE_BASE=12, PAUSE_MIN=12, PAUSE_MAX=768, CRC_SEED=4'h5;
  - the CRC4 table function;
  - state enum sent_tx_state_t.
- One sub-module, sent_crc4_calc: sequential nibble-serial CRC engine with start/nibble_valid/done. The receive-side CRC checker can reuse it.

Test Plan:
- Reset then idle: sent_tx_o=1, frame_ready_o=1 held indefinitely.
- Defaults, status=0, data=24'h000000:
  - crc_o=5;
  - pulses 56,12,12×6,17 ticks;
  - frame 157 ticks = 471 clocks;
  - each low phase 15 clocks;
  - frame_done_o at clock 471.
- status=4'h3, data=24'h123456:
  - crc_o=2;
  - pulse lengths 56,15,13,14,15,16,17,18,14 ticks.
- PAUSE_EN=1, FRAME_TICKS=282, data 0: pause 125 ticks; frame exactly 846 clocks.
- frame_valid_i held high with two words:
  - second sync falls on the clock after the first frame_done_o, with no idle gap;
  - changing data_i mid-frame does not alter the transmitted nibbles.
- reset_tx pulsed during DATA nibble 3:
  - sent_tx_o=1 and busy_o=0 immediately;
  - the next accepted frame starts cleanly with a 56-tick sync.
